// File: rtl/pipeline_hazard_controller.sv
// Hazard detection for a 5-stage pipeline with ID-stage branches and a
// multi-cycle multiply/divide unit: stalls, bubbles, flushes and stall count.
module pipeline_hazard_controller #(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_Id_Rs,
    input  logic [4:0]  IF_Id_Rt,
    input  logic        id_uses_rt,
    input  logic        id_branch,
    input  logic        id_branch_taken,
    input  logic        id_jump,
    input  logic        id_md_start,
    input  logic        id_md_read,
    input  logic        ID_Ex_MemRead,
    input  logic        ID_Ex_Regwrite,
    input  logic [4:0]  ID_Ex_WriteReg,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_MemWriteReg,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        md_busy,
    output logic        md_go,
    output logic [15:0] stall_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LAT_M1 = 4'(MD_LATENCY - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_stall_count;

    logic w_matchEx;
    logic w_matchMem;
    logic w_loadUse;
    logic w_brHaz;
    logic w_mdHaz;
    logic w_stall;
    logic w_mdIssue;

    // Register 0 is hard-wired, so it can never carry a dependency.
    assign w_matchEx  = (ID_Ex_WriteReg != 5'd0) &&
                        ((ID_Ex_WriteReg == IF_Id_Rs) ||
                         (id_uses_rt && (ID_Ex_WriteReg == IF_Id_Rt)));
    assign w_matchMem = (EX_MemWriteReg != 5'd0) &&
                        ((EX_MemWriteReg == IF_Id_Rs) ||
                         (id_uses_rt && (EX_MemWriteReg == IF_Id_Rt)));

    assign w_loadUse = ID_Ex_MemRead && w_matchEx;
    assign w_brHaz   = id_branch && ((ID_Ex_Regwrite && w_matchEx) ||
                                     (EX_MemRead && w_matchMem));
    assign md_busy   = (r_state == S_BUSY);
    assign w_mdHaz   = md_busy && (id_md_start || id_md_read);
    assign w_stall   = w_loadUse || w_brHaz || w_mdHaz;
    assign w_mdIssue = id_md_start && !w_stall && !md_busy;

    assign pc_write     = !rst_n || !w_stall;
    assign if_id_write  = !rst_n || !w_stall;
    assign id_ex_bubble = rst_n && w_stall;
    assign if_id_flush  = rst_n && !w_stall && (id_jump || (id_branch && id_branch_taken));
    assign md_go        = rst_n && w_mdIssue;
    assign stall_count  = r_stall_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_mdIssue) begin
                        r_state <= S_BUSY;
                        r_cnt   <= LAT_M1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: load-use, branch, register
// zero, multiply/divide sequencing, stall counter saturation and reset.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  IF_Id_Rs, IF_Id_Rt;
    logic        id_uses_rt, id_branch, id_branch_taken, id_jump;
    logic        id_md_start, id_md_read;
    logic        ID_Ex_MemRead, ID_Ex_Regwrite;
    logic [4:0]  ID_Ex_WriteReg;
    logic        EX_MemRead;
    logic [4:0]  EX_MemWriteReg;
    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic        md_busy, md_go;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;

    pipeline_hazard_controller #(.MD_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_Id_Rs(IF_Id_Rs), .IF_Id_Rt(IF_Id_Rt),
        .id_uses_rt(id_uses_rt), .id_branch(id_branch),
        .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .id_md_start(id_md_start), .id_md_read(id_md_read),
        .ID_Ex_MemRead(ID_Ex_MemRead), .ID_Ex_Regwrite(ID_Ex_Regwrite),
        .ID_Ex_WriteReg(ID_Ex_WriteReg),
        .EX_MemRead(EX_MemRead), .EX_MemWriteReg(EX_MemWriteReg),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .md_busy(md_busy), .md_go(md_go), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Drives every input at once so each directed step is one line.
    task automatic applyStimulus(
        input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
        input logic br, input logic taken, input logic jmp,
        input logic mdStart, input logic mdRead,
        input logic exMemRead, input logic exRegwrite, input logic [4:0] exDest,
        input logic memRead, input logic [4:0] memDest);
        IF_Id_Rs        = rs;
        IF_Id_Rt        = rt;
        id_uses_rt      = usesRt;
        id_branch       = br;
        id_branch_taken = taken;
        id_jump         = jmp;
        id_md_start     = mdStart;
        id_md_read      = mdRead;
        ID_Ex_MemRead   = exMemRead;
        ID_Ex_Regwrite  = exRegwrite;
        ID_Ex_WriteReg  = exDest;
        EX_MemRead      = memRead;
        EX_MemWriteReg  = memDest;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Checks the four pipeline-control outputs in one call.
    task automatic checkCtrl(input string tag, input logic pcW, input logic ifW,
                             input logic bub, input logic fl);
        checkOutput({tag, ".pc_write"}, {15'd0, pc_write}, {15'd0, pcW});
        checkOutput({tag, ".if_id_write"}, {15'd0, if_id_write}, {15'd0, ifW});
        checkOutput({tag, ".id_ex_bubble"}, {15'd0, id_ex_bubble}, {15'd0, bub});
        checkOutput({tag, ".if_id_flush"}, {15'd0, if_id_flush}, {15'd0, fl});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0);
        @(negedge clk);
        nextCycle();
        #1;
        checkCtrl("reset", 1, 1, 0, 0);
        checkOutput("reset.md_go", {15'd0, md_go}, 16'd0);
        checkOutput("reset.md_busy", {15'd0, md_busy}, 16'd0);
        checkOutput("reset.stall_count", stall_count, 16'd0);

        // Reset with a load-use hazard present still forces non-stall outputs
        applyStimulus(5'd8, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0);
        #1;
        checkCtrl("reset_hazard", 1, 1, 0, 0);

        nextCycle();
        rst_n = 1'b1;
        applyStimulus(5'd8, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0);
        #1;
        checkCtrl("loaduse", 0, 0, 1, 0);
        nextCycle();
        applyStimulus(5'd8, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 1, 5'd8);
        #1;
        checkCtrl("loaduse_after", 1, 1, 0, 0);
        checkOutput("loaduse.stall_count", stall_count, 16'd1);

        nextCycle();
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd0, 0, 5'd0);
        #1;
        checkCtrl("reg_zero", 1, 1, 0, 0);

        nextCycle();
        applyStimulus(5'd3, 5'd8, 0, 0, 0, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0);
        #1;
        checkCtrl("rt_unused", 1, 1, 0, 0);
        nextCycle();
        applyStimulus(5'd3, 5'd8, 1, 0, 0, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0);
        #1;
        checkCtrl("rt_used", 0, 0, 1, 0);
        nextCycle();
        checkOutput("rt.stall_count", stall_count, 16'd2);

        // Taken branch on a load in EX: two stalls, then the flush
        applyStimulus(5'd9, 5'd0, 0, 1, 1, 0, 0, 0, 1, 1, 5'd9, 0, 5'd0);
        #1;
        checkCtrl("br_load_1", 0, 0, 1, 0);
        nextCycle();
        applyStimulus(5'd9, 5'd0, 0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 1, 5'd9);
        #1;
        checkCtrl("br_load_2", 0, 0, 1, 0);
        nextCycle();
        applyStimulus(5'd9, 5'd0, 0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd9);
        #1;
        checkCtrl("br_load_3", 1, 1, 0, 1);
        checkOutput("br_load.stall_count", stall_count, 16'd4);

        nextCycle();
        applyStimulus(5'd4, 5'd9, 1, 1, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd0);
        #1;
        checkCtrl("br_alu", 0, 0, 1, 0);
        nextCycle();
        applyStimulus(5'd4, 5'd9, 1, 1, 0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0);
        #1;
        checkCtrl("br_not_taken", 1, 1, 0, 0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0);
        #1;
        checkCtrl("jump", 1, 1, 0, 1);
        checkOutput("br_alu.stall_count", stall_count, 16'd5);

        // mult followed immediately by mfhi
        nextCycle();
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0);
        #1;
        checkOutput("mult.md_go", {15'd0, md_go}, 16'd1);
        checkOutput("mult.md_busy", {15'd0, md_busy}, 16'd0);
        checkCtrl("mult", 1, 1, 0, 0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("mfhi_busy%0d.md_busy", i), {15'd0, md_busy}, 16'd1);
            checkOutput($sformatf("mfhi_busy%0d.md_go", i), {15'd0, md_go}, 16'd0);
            checkOutput($sformatf("mfhi_busy%0d.pc_write", i), {15'd0, pc_write}, 16'd0);
            nextCycle();
        end
        #1;
        checkOutput("mfhi_done.md_busy", {15'd0, md_busy}, 16'd0);
        checkCtrl("mfhi_done", 1, 1, 0, 0);
        checkOutput("mfhi.stall_count", stall_count, 16'd9);

        // Back-to-back mult: second md_go exactly 5 cycles after the first
        nextCycle();
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0);
        for (int i = 0; i <= 5; i++) begin
            #1;
            checkOutput($sformatf("b2b%0d.md_go", i), {15'd0, md_go},
                        (i == 0 || i == 5) ? 16'd1 : 16'd0);
            checkOutput($sformatf("b2b%0d.pc_write", i), {15'd0, pc_write},
                        (i == 0 || i == 5) ? 16'd1 : 16'd0);
            nextCycle();
        end
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0);
        #1;
        checkOutput("b2b_second.md_busy", {15'd0, md_busy}, 16'd1);
        checkOutput("b2b.stall_count", stall_count, 16'd13);

        // Saturation: 70000 forced load-use stalls
        applyStimulus(5'd7, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd7, 0, 5'd0);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        checkOutput("sat.stall_count", stall_count, 16'hFFFF);
        checkOutput("sat.md_busy", {15'd0, md_busy}, 16'd0);

        applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0);
        #1;
        checkOutput("sat_mult.md_go", {15'd0, md_go}, 16'd1);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0);
        #1;
        checkOutput("pre_rst.md_busy", {15'd0, md_busy}, 16'd1);
        checkOutput("pre_rst.stall_count", stall_count, 16'hFFFF);
        rst_n = 1'b0;
        #1;
        checkCtrl("rst_busy", 1, 1, 0, 0);
        nextCycle();
        #1;
        checkOutput("post_rst.md_busy", {15'd0, md_busy}, 16'd0);
        checkOutput("post_rst.stall_count", stall_count, 16'd0);
        rst_n = 1'b1;
        #1;
        checkCtrl("post_rst_mfhi", 1, 1, 0, 0);
        nextCycle();
        checkOutput("post_rst_idle.md_busy", {15'd0, md_busy}, 16'd0);
        checkOutput("post_rst_idle.stall_count", stall_count, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
Parameters (name, default, meaning):
REQ-001 MD_LATENCY, 4, cycles the multiply/divide unit stays busy after a start (legal range 2..15).
Ports (name  direction  width  meaning):
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 IF_Id_Rs, IF_Id_Rt  input  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rt  input  1  the ID instruction reads Rt.
REQ-006 id_branch  input  1  the ID instruction is a beq/bne, compared in ID.
REQ-007 id_branch_taken  input  1  the ID comparator result; valid only when id_branch=1.
REQ-008 id_jump  input  1  the ID instruction is j/jal/jr.
REQ-009 id_md_start  input  1  the ID instruction is mult/div.
REQ-010 id_md_read  input  1  the ID instruction is mfhi/mflo.
REQ-011 ID_Ex_MemRead, ID_Ex_Regwrite  input  1 each  control bits of the instruction in EX.
REQ-012 ID_Ex_WriteReg  input  5  destination register of the instruction in EX.
REQ-013 EX_MemRead  input  1  the instruction in MEM is a load.
REQ-014 EX_MemWriteReg  input  5  destination register of the instruction in MEM.
REQ-015 pc_write, if_id_write  output  1 each  enables for the PC register and the IF/ID register.
REQ-016 id_ex_bubble  output  1  zero the ID/EX control bits this cycle.
REQ-017 if_id_flush  output  1  squash the IF/ID contents at the next edge.
REQ-018 md_busy  output  1  the multiply/divide unit is occupied.
REQ-019 md_go  output  1  single-cycle start strobe to the multiply/divide unit.
REQ-020 stall_count  output  16  saturating count of stall cycles.

Function
REQ-021 match(r) SHALL be true when r!=0 and (r==IF_Id_Rs or (id_uses_rt and r==IF_Id_Rt)).
REQ-022 load_use SHALL be true when ID_Ex_MemRead and match(ID_Ex_WriteReg).
REQ-023 br_haz SHALL be true when id_branch and one of these holds:
- ID_Ex_Regwrite and match(ID_Ex_WriteReg); or
- EX_MemRead and match(EX_MemWriteReg).
A branch on a load in EX therefore stalls 2 cycles in total.
REQ-024 md_haz SHALL be true when md_busy and (id_md_start or id_md_read).
REQ-025 stall SHALL equal load_use or br_haz or md_haz, evaluated combinationally in the same cycle.
REQ-026 When stall=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
REQ-027 When stall=0: pc_write=1, if_id_write=1, id_ex_bubble=0, and if_id_flush=(id_jump or (id_branch and id_branch_taken)).
REQ-028 The MD FSM SHALL have states IDLE, BUSY and DONE, and md_busy=1 exactly in BUSY.
REQ-029 IDLE->BUSY SHALL occur when id_md_start=1 and stall=0; md_go=1 in that cycle only, and cnt<=MD_LATENCY-1.
REQ-030 In BUSY, cnt SHALL decrement each cycle; at cnt==0 the FSM SHALL move to DONE.
REQ-031 DONE SHALL last one cycle and then return to IDLE; a start in DONE with stall=0 SHALL go to BUSY directly.
REQ-032 id_md_start while BUSY SHALL stall the instruction and produce no md_go; it issues on the first non-stalled cycle.
REQ-033 stall_count SHALL increment on every cycle with stall=1 and hold at 16'hFFFF.
REQ-034 Register 0 SHALL never create a hazard.

Reset
REQ-035 With rst_n=0 at a clock edge: MD FSM=IDLE, cnt=0, stall_count=0.
REQ-036 During reset, the combinational outputs SHALL be forced to pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, md_go=0.
REQ-037 A reset asserted while the FSM is in BUSY SHALL abandon the operation, with md_busy=0 on the next cycle.

Verification
REQ-038 Load-use: ID_Ex_MemRead=1, ID_Ex_WriteReg=8, IF_Id_Rs=8 -> exactly 1 stall cycle (pc_write=0, id_ex_bubble=1), then stall_count=1.
REQ-039 Branch after load: id_branch=1, Rs=9, ID_Ex_MemRead=1 with dest 9 -> 2 consecutive stalls, then if_id_flush=1 if taken.
REQ-040 Register zero: ID_Ex_MemRead=1, WriteReg=0, IF_Id_Rs=0 -> no stall.
REQ-041 MD issue and mfhi: MD_LATENCY=4, mult issued, mfhi follows immediately -> md_go pulses once, md_busy=1 for 4 cycles, mfhi stalls 4 cycles.
REQ-042 Back-to-back mult: two mult instructions in a row -> second md_go occurs 5 cycles after the first (4 BUSY cycles plus 1 stall-free cycle).
REQ-043 Saturation and reset: force stall for 70000 cycles -> stall_count=16'hFFFF; then rst_n=0 during BUSY -> stall_count=0 and md_busy=0 next cycle.
